// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings (common with the TX frame builder),
// receive FSM states, data width and the parity helpers.
// Pure declarations; no clocked logic.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // 2'b11 is treated like PARITY_NONE: the frame carries no parity bit.
    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
    endfunction

    // Parity bit the transmitter must have sent for this byte.
    function automatic logic parity_expected(input logic [1:0] ptype,
                                             input logic [DATA_BITS-1:0] data);
        return (ptype == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line, both flops reset to idle-high.
// Latency: 2 clk from d_i to q_o.
// No backpressure: free-running every clk.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Resample the asynchronous line twice; reset to the idle level so no false start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deserializer: start detect, 8 data bits LSB first, optional parity, stop check.
// Latency: data_valid 1 clk after the stop-bit sample tick (+2 clk with UART_RX_SYNC_EN defined).
// No backpressure: data_valid is a one-clk strobe; results hold until the next frame.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OSR = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (rx_in),
        .q_o     (rx_s)
    );
`else
    assign rx_s = rx_in;
`endif

    rx_state_t            state_q,  state_d;
    logic [TW-1:0]        tick_q,   tick_d;
    logic [BW-1:0]        bit_q,    bit_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [1:0]           ptype_q,  ptype_d;
    logic                 pmis_q,   pmis_d;
    logic [DATA_BITS-1:0] dout_q,   dout_d;
    logic                 valid_q,  valid_d;
    logic                 perr_q,   perr_d;
    logic                 ferr_q,   ferr_d;

    // Next-state and frame datapath; everything only advances on a baud tick.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ptype_d = ptype_q;
        pmis_d  = pmis_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        if (baud_tick) begin
            case (state_q)
                RX_IDLE: begin
                    tick_d = '0;
                    if (!rx_s) state_d = RX_START;
                end
                RX_START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            // Parity mode is frozen here so mid-frame changes are ignored.
                            ptype_d = parity_type;
                            bit_d   = '0;
                            pmis_d  = 1'b0;
                            state_d = RX_DATA;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST)
                            state_d = parity_enabled(ptype_q) ? RX_PARITY : RX_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        pmis_d  = (rx_s != parity_expected(ptype_q, shift_q));
                        state_d = RX_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        perr_d  = pmis_q;
                        ferr_d  = ~rx_s;
                        state_d = rx_s ? RX_IDLE : RX_BREAK;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                RX_BREAK: begin
                    // A line stuck low must go high before another start can be seen.
                    tick_d = '0;
                    if (rx_s) state_d = RX_IDLE;
                end
                default: begin
                    tick_d  = '0;
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ptype_q <= PARITY_NONE;
            pmis_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ptype_q <= ptype_d;
            pmis_q  <= pmis_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out      = dout_q;
    assign data_valid    = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame, OSR = 16 with baud_tick held high (one tick per clk).
// Frames are driven bit by bit on the falling edge; outputs are checked just after it.
// Works with and without UART_RX_SYNC_EN (latency shifts by 2 clk).
module tb_uart_rx_frame;

    localparam int OSR = 16;
`ifdef UART_RX_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif
    localparam int LAT_PAR   = 169 + SD;
    localparam int LAT_NOPAR = 153 + SD;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       baud_tick;
    logic       rx_in;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    uart_rx_frame #(.OSR(OSR)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .baud_tick     (baud_tick),
        .rx_in         (rx_in),
        .parity_type   (parity_type),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc       = 0;
    int vcount    = 0;
    int last_vcyc = 0;
    int start_cyc = 0;
    int vbase     = 0;
    int passed    = 0;
    int total     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Count valid strobes and remember when the latest one was seen.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            vcount    <= vcount + 1;
            last_vcyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic hold(input logic b, input int n);
        rx_in = b;
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, stop bit; each OSR clks.
    // parity_type is switched to pt_mid after the start bit to show it is latched.
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic stop_bit, input logic [1:0] pt_mid);
        start_cyc = cyc;
        hold(1'b0, OSR);
        parity_type = pt_mid;
        for (int i = 0; i < 8; i++) hold(d[i], OSR);
        if (par_en) hold(par_bit, OSR);
        hold(stop_bit, OSR);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        baud_tick   = 1'b1;
        rx_in       = 1'b1;
        parity_type = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_data_out",      32'(data_out),      32'h00);
        check("reset_data_valid",    32'(data_valid),    32'h0);
        check("reset_parity_error",  32'(parity_error),  32'h0);
        check("reset_framing_error", 32'(framing_error), 32'h0);
        check("reset_busy",          32'(busy),          32'h0);
        reset_n = 1'b1;
        hold(1'b1, 4);

        // Even parity, 0xA5 has four ones -> parity bit 0 is correct.
        parity_type = 2'b10;
        vbase = vcount;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 2'b10);
        check("even_vcount",  32'(vcount - vbase),          32'd1);
        check("even_latency", 32'(last_vcyc - start_cyc),  32'(LAT_PAR));
        check("even_data",    32'(data_out),                32'hA5);
        check("even_perr",    32'(parity_error),            32'h0);
        check("even_ferr",    32'(framing_error),           32'h0);
        check("even_busy",    32'(busy),                    32'h0);

        // Odd parity, parity bit 0 is wrong; parity_type drops to 00 mid-frame (ignored).
        parity_type = 2'b01;
        vbase = vcount;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 2'b00);
        check("odd_vcount", 32'(vcount - vbase), 32'd1);
        check("odd_data",   32'(data_out),       32'hA5);
        check("odd_perr",   32'(parity_error),   32'h1);
        check("odd_ferr",   32'(framing_error),  32'h0);

        // No parity, two frames back to back.
        parity_type = 2'b00;
        vbase = vcount;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 2'b00);
        check("nopar1_latency", 32'(last_vcyc - start_cyc), 32'(LAT_NOPAR));
        check("nopar1_data",    32'(data_out),               32'h3C);
        check("nopar1_perr",    32'(parity_error),           32'h0);
        check("nopar1_ferr",    32'(framing_error),          32'h0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 2'b00);
        check("nopar2_vcount",  32'(vcount - vbase),         32'd2);
        check("nopar2_latency", 32'(last_vcyc - start_cyc),  32'(LAT_NOPAR));
        check("nopar2_data",    32'(data_out),               32'hC3);

        // 0x55 with a low stop bit, then the line stays low (break).
        vbase = vcount;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 2'b00);
        check("brk_vcount", 32'(vcount - vbase), 32'd1);
        check("brk_data",   32'(data_out),       32'h55);
        check("brk_ferr",   32'(framing_error),  32'h1);
        check("brk_perr",   32'(parity_error),   32'h0);
        check("brk_busy",   32'(busy),           32'h1);
        hold(1'b0, 100);
        #1;
        check("brk_low_busy",   32'(busy),           32'h1);
        check("brk_low_vcount", 32'(vcount - vbase), 32'd1);
        hold(1'b1, 4);
        #1;
        check("brk_release_busy",   32'(busy),           32'h0);
        check("brk_release_vcount", 32'(vcount - vbase), 32'd1);

        // Three-clk low glitch: false start rejected at the mid-start sample.
        vbase = vcount;
        hold(1'b0, 3);
        #1;
        check("glitch_busy_high", 32'(busy), 32'h1);
        hold(1'b1, 20);
        #1;
        check("glitch_busy_low", 32'(busy),           32'h0);
        check("glitch_vcount",   32'(vcount - vbase), 32'd0);

        // Reset pulse during the data bits of a 0x77 frame, then a clean 0x81.
        vbase = vcount;
        hold(1'b0, OSR);
        hold(1'b1, OSR);
        hold(1'b1, OSR);
        hold(1'b1, 5);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("abort_busy", 32'(busy),     32'h0);
        check("abort_data", 32'(data_out), 32'h00);
        hold(1'b1, 40);
        #1;
        check("abort_vcount", 32'(vcount - vbase), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 2'b00);
        check("clean_vcount",  32'(vcount - vbase),         32'd1);
        check("clean_latency", 32'(last_vcyc - start_cyc),  32'(LAT_NOPAR));
        check("clean_data",    32'(data_out),                32'h81);
        check("clean_perr",    32'(parity_error),            32'h0);
        check("clean_ferr",    32'(framing_error),           32'h0);
        check("clean_busy",    32'(busy),                    32'h0);

        hold(1'b1, 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
